// File: rtl/ro_freq_meter.sv
// ro_freq_meter: counts synchronised ring-oscillator edges over a fixed gate window
// and holds a scaled, saturated 8-bit code for register readout.
module ro_freq_meter #(
  parameter int GATE_CYCLES = 1024,
  parameter int CNT_W = 16,
  parameter int SHIFT = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       ro_in,
  output logic [7:0] ro_code,
  output logic       valid,
  output logic       ovf,
  output logic       busy
);
  localparam int GW = $clog2(GATE_CYCLES);
  typedef enum logic [1:0] {IDLE, CLEAR, GATE, DONE} state_t;
  state_t state_q, state_d;
  logic [2:0] sync_q;
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [GW-1:0] gate_cnt_q, gate_cnt_d;
  logic sat_q, sat_d, ovf_q, ovf_d, valid_q, valid_d, rise_p;
  logic [7:0] code_q, code_d;
  logic [31:0] shifted;
  assign rise_p = sync_q[1] & ~sync_q[2];
  assign shifted = 32'(edge_cnt_q >> SHIFT);
  always_comb begin
    state_d = state_q;
    edge_cnt_d = edge_cnt_q;
    gate_cnt_d = gate_cnt_q;
    sat_d = sat_q;
    code_d = code_q;
    ovf_d = ovf_q;
    valid_d = 1'b0;
    case (state_q)
      IDLE: state_d = enable ? CLEAR : IDLE;
      CLEAR: begin
        edge_cnt_d = '0;
        sat_d = 1'b0;
        gate_cnt_d = GW'(GATE_CYCLES - 1);
        state_d = enable ? GATE : IDLE;
      end
      GATE: begin
        // an edge arriving while the counter is full marks the window as saturated
        if (rise_p) begin
          edge_cnt_d = (&edge_cnt_q) ? edge_cnt_q : edge_cnt_q + CNT_W'(1);
          sat_d = sat_q | (&edge_cnt_q);
        end
        gate_cnt_d = gate_cnt_q - GW'(1);
        state_d = !enable ? IDLE : (gate_cnt_q == '0) ? DONE : GATE;
      end
      DONE: begin
        code_d = (shifted > 32'd255) ? 8'hFF : shifted[7:0];
        ovf_d = sat_q | (shifted > 32'd255);
        valid_d = 1'b1;
        state_d = enable ? CLEAR : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sync_q <= '0;
      edge_cnt_q <= '0;
      gate_cnt_q <= '0;
      sat_q <= 1'b0;
      code_q <= '0;
      ovf_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q <= {sync_q[1:0], ro_in};
      edge_cnt_q <= edge_cnt_d;
      gate_cnt_q <= gate_cnt_d;
      sat_q <= sat_d;
      code_q <= code_d;
      ovf_q <= ovf_d;
      valid_q <= valid_d;
    end
  end
  assign ro_code = code_q;
  assign valid = valid_q;
  assign ovf = ovf_q;
  assign busy = state_q != IDLE;
endmodule

// File: tb/tb_ro_freq_meter.sv
// tb_ro_freq_meter: drives three meter configurations with periodic ro_in patterns and
// checks window timing and codes against an edge-count model of each window.
module tb_ro_freq_meter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;
  logic [2:0] en, ro, valid_v, ovf_v, busy_v;
  logic [7:0] code_v [3];
  int per [3];
  int ph [3];
  logic lvl [3];
  int tick;
  int checks = 0;
  int errors = 0;
  localparam int GC [3] = '{1024, 1024, 256};
  localparam int SH [3] = '{2, 0, 0};
  localparam int CW [3] = '{16, 16, 4};

  ro_freq_meter u0 (.clk(clk), .rst_n(rst_n), .enable(en[0]), .ro_in(ro[0]),
    .ro_code(code_v[0]), .valid(valid_v[0]), .ovf(ovf_v[0]), .busy(busy_v[0]));
  ro_freq_meter #(.SHIFT(0)) u1 (.clk(clk), .rst_n(rst_n), .enable(en[1]), .ro_in(ro[1]),
    .ro_code(code_v[1]), .valid(valid_v[1]), .ovf(ovf_v[1]), .busy(busy_v[1]));
  ro_freq_meter #(.GATE_CYCLES(256), .CNT_W(4), .SHIFT(0)) u2 (.clk(clk), .rst_n(rst_n),
    .enable(en[2]), .ro_in(ro[2]), .ro_code(code_v[2]), .valid(valid_v[2]),
    .ovf(ovf_v[2]), .busy(busy_v[2]));

  // square-wave ro_in sources: period 0 means hold at lvl
  initial begin
    tick = 0;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 3; d++)
        ro[d] = (per[d] == 0) ? lvl[d] : (((tick + ph[d]) % per[d]) < per[d] / 2);
      tick++;
    end
  end

  function automatic int exp_code(int d, int n);
    int mx = (1 << CW[d]) - 1;
    int sh = ((n > mx) ? mx : n) >> SH[d];
    return (sh > 255) ? 255 : sh;
  endfunction
  function automatic bit exp_ovf(int d, int n);
    int mx = (1 << CW[d]) - 1;
    return (n > mx) || ((((n > mx) ? mx : n) >> SH[d]) > 255);
  endfunction
  // a periodic source gives floor or ceil of GATE/period edges depending on phase
  function automatic bit ok_any(int d, int p, logic [7:0] c, logic o);
    int lo = (p == 0) ? 0 : GC[d] / p;
    int hi = (p == 0) ? 0 : (GC[d] + p - 1) / p;
    for (int n = lo; n <= hi; n++)
      if (c === 8'(exp_code(d, n)) && o === exp_ovf(d, n)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic setup(input int d, input int p, input int phase);
    per[d] = p;
    ph[d] = phase;
    repeat (8) @(negedge clk);
  endtask
  task automatic run_window(input int d, input int budget, output int n,
                            output logic [7:0] c, output logic o, output logic pa);
    n = -1;
    c = 8'h00;
    o = 1'b0;
    pa = 1'b0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (valid_v[d]) begin
        n = i;
        c = code_v[d];
        o = ovf_v[d];
        break;
      end
    end
    if (n >= 0) begin
      @(negedge clk);
      pa = valid_v[d];
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if ({code_v[d], valid_v[d], ovf_v[d], busy_v[d]} !== 11'b0) begin
        errors++;
        $display("FAIL reset_%0d: got code=%0d valid=%b ovf=%b busy=%b, expected all 0",
                 d, code_v[d], valid_v[d], ovf_v[d], busy_v[d]);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_continuous;
    int n;
    logic [7:0] c;
    logic o, pa;
    setup(0, 8, 0);
    en[0] = 1'b1;
    for (int w = 0; w < 3; w++) begin
      run_window(0, GC[0] + 10, n, c, o, pa);
      checks++;
      if (n !== ((w == 0) ? GC[0] + 3 : GC[0] + 1) || pa !== 1'b0) begin
        errors++;
        $display("FAIL cont_timing_%0d: got latency %0d pulse_after=%b, expected %0d and 0",
                 w, n, pa, (w == 0) ? GC[0] + 3 : GC[0] + 1);
      end
      checks++;
      if (!ok_any(0, 8, c, o)) begin
        errors++;
        $display("FAIL cont_code_%0d: got code=%0d ovf=%b, expected code=32 ovf=0", w, c, o);
      end
    end
    en[0] = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_saturate;
    int n;
    logic [7:0] c;
    logic o, pa;
    setup(1, 4, 0);
    en[1] = 1'b1;
    run_window(1, GC[1] + 10, n, c, o, pa);
    checks++;
    if (n !== GC[1] + 3 || c !== 8'd255 || o !== 1'b1) begin
      errors++;
      $display("FAIL sat_code: got latency %0d code=%0d ovf=%b, expected %0d 255 1",
               n, c, o, GC[1] + 3);
    end
    per[1] = 8;
    run_window(1, GC[1] + 10, n, c, o, pa);
    run_window(1, GC[1] + 10, n, c, o, pa);
    checks++;
    if (n !== GC[1] + 1 || !ok_any(1, 8, c, o)) begin
      errors++;
      $display("FAIL sat_recover: got latency %0d code=%0d ovf=%b, expected %0d 128 0",
               n, c, o, GC[1] + 1);
    end
    en[1] = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_hold;
    int n;
    logic [7:0] c;
    logic o, pa;
    lvl[0] = 1'b0;
    setup(0, 0, 0);
    en[0] = 1'b1;
    for (int w = 0; w < 4; w++) begin
      if (w == 1) lvl[0] = 1'b1;
      run_window(0, GC[0] + 10, n, c, o, pa);
      checks++;
      if (n !== ((w == 0) ? GC[0] + 3 : GC[0] + 1) || pa !== 1'b0) begin
        errors++;
        $display("FAIL hold_timing_%0d: got latency %0d, expected %0d", w, n,
                 (w == 0) ? GC[0] + 3 : GC[0] + 1);
      end
      if (w != 1) begin
        checks++;
        if (!ok_any(0, 0, c, o)) begin
          errors++;
          $display("FAIL hold_code_%0d: got code=%0d ovf=%b, expected 0 0", w, c, o);
        end
      end
    end
    en[0] = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_abort;
    int n;
    logic [7:0] c;
    logic o, pa, seen;
    setup(0, 8, 0);
    en[0] = 1'b1;
    run_window(0, GC[0] + 10, n, c, o, pa);
    repeat (500) @(negedge clk);
    en[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (busy_v[0] !== 1'b0) begin
      errors++;
      $display("FAIL abort_busy: got busy=%b, expected 0", busy_v[0]);
    end
    seen = 1'b0;
    repeat (1100) begin
      @(negedge clk);
      seen |= valid_v[0];
    end
    checks++;
    if (seen !== 1'b0 || code_v[0] !== 8'd32 || ovf_v[0] !== 1'b0) begin
      errors++;
      $display("FAIL abort_hold: got valid_seen=%b code=%0d ovf=%b, expected 0 32 0",
               seen, code_v[0], ovf_v[0]);
    end
    en[0] = 1'b1;
    run_window(0, GC[0] + 10, n, c, o, pa);
    checks++;
    if (n !== GC[0] + 3 || !ok_any(0, 8, c, o)) begin
      errors++;
      $display("FAIL abort_restart: got latency %0d code=%0d, expected %0d 32", n, c, GC[0] + 3);
    end
    en[0] = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_done_drop;
    int n;
    logic [7:0] c;
    logic o, pa;
    setup(0, 8, 0);
    en[0] = 1'b1;
    run_window(0, GC[0] + 10, n, c, o, pa);
    repeat (GC[0]) @(negedge clk);
    en[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (valid_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || code_v[0] !== 8'd32) begin
      errors++;
      $display("FAIL done_drop: got valid=%b busy=%b code=%0d, expected 1 0 32",
               valid_v[0], busy_v[0], code_v[0]);
    end
    @(negedge clk);
    checks++;
    if (valid_v[0] !== 1'b0) begin
      errors++;
      $display("FAIL done_drop_pulse: got valid=%b, expected 0", valid_v[0]);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int n;
    logic [7:0] c;
    logic o, pa;
    setup(0, 8, 0);
    en[0] = 1'b1;
    repeat (300) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({code_v[0], valid_v[0], ovf_v[0], busy_v[0]} !== 11'b0) begin
      errors++;
      $display("FAIL reset_mid: got code=%0d valid=%b ovf=%b busy=%b, expected all 0",
               code_v[0], valid_v[0], ovf_v[0], busy_v[0]);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy_v[0] !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_busy: got busy=%b, expected 1", busy_v[0]);
    end
    run_window(0, GC[0] + 10, n, c, o, pa);
    checks++;
    if (n !== GC[0] + 2 || !ok_any(0, 8, c, o)) begin
      errors++;
      $display("FAIL reset_release_win: got latency %0d code=%0d, expected %0d 32",
               n, c, GC[0] + 2);
    end
    en[0] = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_counter_sat;
    int n;
    logic [7:0] c;
    logic o, pa;
    setup(2, 8, 0);
    en[2] = 1'b1;
    run_window(2, GC[2] + 10, n, c, o, pa);
    checks++;
    if (n !== GC[2] + 3 || c !== 8'd15 || o !== 1'b1) begin
      errors++;
      $display("FAIL cnt_sat: got latency %0d code=%0d ovf=%b, expected %0d 15 1",
               n, c, o, GC[2] + 3);
    end
    en[2] = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_glitch;
    logic seen;
    en[0] = 1'b1;
    #2 en[0] = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen |= busy_v[0];
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL glitch: got busy seen=%b, expected 0", seen);
    end
  endtask

  task automatic test_random;
    int n, d, p;
    logic [7:0] c;
    logic o, pa;
    for (int it = 0; it < 9; it++) begin
      d = it % 3;
      p = $urandom_range(5, 40);
      setup(d, p, $urandom_range(0, p - 1));
      en[d] = 1'b1;
      for (int w = 0; w < 2; w++) begin
        run_window(d, GC[d] + 10, n, c, o, pa);
        checks++;
        if (n !== ((w == 0) ? GC[d] + 3 : GC[d] + 1) || pa !== 1'b0 || !ok_any(d, p, c, o)) begin
          errors++;
          $display("FAIL rand_%0d_%0d: dut %0d period %0d got latency %0d code=%0d ovf=%b, expected %0d code=%0d ovf=%b (+/-1 edge)",
                   it, w, d, p, n, c, o, (w == 0) ? GC[d] + 3 : GC[d] + 1,
                   exp_code(d, GC[d] / p), exp_ovf(d, GC[d] / p));
        end
      end
      en[d] = 1'b0;
      repeat (3) @(negedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    en = 3'b000;
    for (int d = 0; d < 3; d++) begin
      per[d] = 8;
      ph[d] = 0;
      lvl[d] = 1'b0;
    end
    test_reset;
    test_glitch;
    test_continuous;
    test_saturate;
    test_hold;
    test_abort;
    test_done_drop;
    test_counter_sat;
    test_random;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
